// File: rtl/mmc_spi_byte_layer.sv
// Byte-level SPI mode-0 master below the MMC command sequencers: one byte per request, MSB first.
// Optional completed-byte counter on oBYTE_COUNT is built only when MMC_SPI_BYTE_COUNT_EN is defined.
module mmc_spi_byte_layer #(
    parameter int P_DIV_W = 8
) (
    input  logic               iCLOCK,
    input  logic               iRESET,
    input  logic               iRESET_SYNC,
    input  logic [P_DIV_W-1:0] iDIV,
    input  logic               iREQ,
    input  logic               iCS,
    input  logic [7:0]         iDATA,
    output logic               oBUSY,
    output logic               oVALID,
    output logic [7:0]         oDATA,
    output logic               oINFO_MISO,
    output logic [31:0]        oBYTE_COUNT,
    output logic               oSPI_CLK,
    output logic               oSPI_MOSI,
    output logic               oSPI_CS,
    input  logic               iSPI_MISO
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SHIFT_LOW  = 2'd1,
        ST_SHIFT_HIGH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [P_DIV_W-1:0] r_half_cnt;
    logic [P_DIV_W-1:0] w_half_cnt_nxt;
    logic [P_DIV_W-1:0] r_div;
    logic [P_DIV_W-1:0] w_div_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         r_tx;
    logic [7:0]         w_tx_nxt;
    logic [7:0]         r_rx;
    logic [7:0]         w_rx_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [7:0]         r_data;
    logic [7:0]         w_data_nxt;
    logic               r_miso;
    logic               r_sck;
    logic               w_sck_nxt;
    logic               r_mosi;
    logic               w_mosi_nxt;
    logic               r_cs;
    logic               w_cs_nxt;
    logic               w_half_done;

    assign w_half_done = (r_half_cnt == r_div);

    // State register
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_state <= ST_IDLE;
        end else if (iRESET_SYNC) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath decode
    always_comb begin
        w_state_nxt    = r_state;
        w_half_cnt_nxt = r_half_cnt;
        w_div_nxt      = r_div;
        w_bit_idx_nxt  = r_bit_idx;
        w_tx_nxt       = r_tx;
        w_rx_nxt       = r_rx;
        w_busy_nxt     = r_busy;
        w_valid_nxt    = 1'b0;
        w_data_nxt     = r_data;
        w_sck_nxt      = r_sck;
        w_mosi_nxt     = r_mosi;
        w_cs_nxt       = r_cs;

        case (r_state)
            ST_IDLE: begin
                w_cs_nxt   = iCS;
                w_mosi_nxt = 1'b1;
                w_sck_nxt  = 1'b0;
                w_busy_nxt = 1'b0;
                if (iREQ) begin
                    w_tx_nxt       = {iDATA[6:0], 1'b0};
                    w_div_nxt      = iDIV;
                    w_busy_nxt     = 1'b1;
                    w_mosi_nxt     = iDATA[7];
                    w_bit_idx_nxt  = 3'd7;
                    w_half_cnt_nxt = '0;
                    w_state_nxt    = ST_SHIFT_LOW;
                end else begin
                    w_half_cnt_nxt = '0;
                end
            end
            ST_SHIFT_LOW: begin
                if (w_half_done) begin
                    w_half_cnt_nxt = '0;
                    w_sck_nxt      = 1'b1;
                    w_rx_nxt       = {r_rx[6:0], iSPI_MISO};
                    w_state_nxt    = ST_SHIFT_HIGH;
                end else begin
                    w_half_cnt_nxt = r_half_cnt + P_DIV_W'(1);
                end
            end
            ST_SHIFT_HIGH: begin
                if (w_half_done) begin
                    w_half_cnt_nxt = '0;
                    w_sck_nxt      = 1'b0;
                    if (r_bit_idx == 3'd0) begin
                        w_busy_nxt  = 1'b0;
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = r_rx;
                        w_mosi_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        // r_tx is pre-shifted so its MSB is always the next bit to send
                        w_mosi_nxt    = r_tx[7];
                        w_tx_nxt      = {r_tx[6:0], 1'b0};
                        w_bit_idx_nxt = r_bit_idx - 3'd1;
                        w_state_nxt   = ST_SHIFT_LOW;
                    end
                end else begin
                    w_half_cnt_nxt = r_half_cnt + P_DIV_W'(1);
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_sck_nxt   = 1'b0;
                w_mosi_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_half_cnt <= '0;
            r_div      <= '0;
            r_bit_idx  <= 3'd0;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= 8'h00;
            r_miso     <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b1;
            r_cs       <= 1'b1;
        end else if (iRESET_SYNC) begin
            r_half_cnt <= '0;
            r_div      <= '0;
            r_bit_idx  <= 3'd0;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= 8'h00;
            r_miso     <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b1;
            r_cs       <= 1'b1;
        end else begin
            r_half_cnt <= w_half_cnt_nxt;
            r_div      <= w_div_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_rx       <= w_rx_nxt;
            r_busy     <= w_busy_nxt;
            r_valid    <= w_valid_nxt;
            r_data     <= w_data_nxt;
            r_miso     <= iSPI_MISO;
            r_sck      <= w_sck_nxt;
            r_mosi     <= w_mosi_nxt;
            r_cs       <= w_cs_nxt;
        end
    end

`ifdef MMC_SPI_BYTE_COUNT_EN
    logic [31:0] r_byte_count;

    // Completed-byte counter, stepping together with the oVALID pulse
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_byte_count <= 32'd0;
        end else if (iRESET_SYNC) begin
            r_byte_count <= 32'd0;
        end else if (w_valid_nxt) begin
            r_byte_count <= r_byte_count + 32'd1;
        end else begin
            r_byte_count <= r_byte_count;
        end
    end

    assign oBYTE_COUNT = r_byte_count;
`else
    assign oBYTE_COUNT = 32'd0;
`endif

    assign oBUSY      = r_busy;
    assign oVALID     = r_valid;
    assign oDATA      = r_data;
    assign oINFO_MISO = r_miso;
    assign oSPI_CLK   = r_sck;
    assign oSPI_MOSI  = r_mosi;
    assign oSPI_CS    = r_cs;

endmodule

// File: tb/tb_mmc_spi_byte_layer.sv
// Directed self-checking bench for mmc_spi_byte_layer: timing, loopback data, back-to-back, sync abort, counter.
module tb_mmc_spi_byte_layer;

    logic        clk;
    logic        rst;
    logic        srst;
    logic [7:0]  div;
    logic        req;
    logic        cs;
    logic [7:0]  data_in;
    logic        busy;
    logic        valid;
    logic [7:0]  data_out;
    logic        info_miso;
    logic [31:0] byte_count;
    logic        sck;
    logic        mosi;
    logic        spi_cs;
    logic        miso;

    logic        loopback;
    logic [7:0]  miso_pat;
    int          fall_cnt;
    int          fall_base;
    int          rise_cnt;
    int          valid_cnt;
    int          cs_err;
    logic [7:0]  mosi_cap;
    logic [2:0]  miso_idx;
    int          checks;
    int          errors;

    mmc_spi_byte_layer #(.P_DIV_W(8)) dut (
        .iCLOCK      (clk),
        .iRESET      (rst),
        .iRESET_SYNC (srst),
        .iDIV        (div),
        .iREQ        (req),
        .iCS         (cs),
        .iDATA       (data_in),
        .oBUSY       (busy),
        .oVALID      (valid),
        .oDATA       (data_out),
        .oINFO_MISO  (info_miso),
        .oBYTE_COUNT (byte_count),
        .oSPI_CLK    (sck),
        .oSPI_MOSI   (mosi),
        .oSPI_CS     (spi_cs),
        .iSPI_MISO   (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign miso_idx = 3'(7 - (fall_cnt - fall_base));
    assign miso     = loopback ? mosi : miso_pat[miso_idx];

    // Card-side observers: SCK edges, MOSI bits on rising SCK, valid pulses, CS stability
    always @(negedge sck) fall_cnt <= fall_cnt + 1;
    always @(posedge sck) begin
        rise_cnt <= rise_cnt + 1;
        mosi_cap <= {mosi_cap[6:0], mosi};
    end
    always @(posedge clk) begin
        if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (busy === 1'b1 && spi_cs !== 1'b0) cs_err <= cs_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one request cycle; returns in cycle T+1
    task automatic start_xfer(input logic [7:0] d, input logic [7:0] dv);
        data_in   = d;
        div       = dv;
        fall_base = fall_cnt;
        req       = 1'b1;
        tick(1);
        req       = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 600) begin
            tick(1);
            n++;
        end
        if (valid !== 1'b1) check(tag, 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] exp_cnt(input logic [31:0] n);
`ifdef MMC_SPI_BYTE_COUNT_EN
        return n;
`else
        return 32'd0 & n;
`endif
    endfunction

    int rbase;
    int vbase;

    initial begin
        checks = 0; errors = 0;
        fall_cnt = 0; fall_base = 0; rise_cnt = 0; valid_cnt = 0; cs_err = 0; mosi_cap = 8'h00;
        rst = 1'b1; srst = 1'b0; div = 8'd0; req = 1'b0; cs = 1'b1; data_in = 8'h00;
        loopback = 1'b1; miso_pat = 8'h00;
        tick(3);
        rst = 1'b0;
        tick(2);

        check("rst_cs",    32'(spi_cs), 32'd1);
        check("rst_sck",   32'(sck),    32'd0);
        check("rst_mosi",  32'(mosi),   32'd1);
        check("rst_busy",  32'(busy),   32'd0);
        check("rst_valid", 32'(valid),  32'd0);
        check("rst_data",  32'(data_out), 32'h00);
        check("rst_count", byte_count,  32'd0);

        // Loopback 0x58 at full speed
        cs = 1'b0;
        tick(1);
        check("idle_cs_follow", 32'(spi_cs), 32'd0);
        rbase = rise_cnt;
        start_xfer(8'h58, 8'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_mosi_msb", 32'(mosi), 32'd0);
        tick(15);
        check("t1_no_valid_t16", 32'(valid), 32'd0);
        tick(1);
        check("t1_valid_t17", 32'(valid), 32'd1);
        check("t1_data", 32'(data_out), 32'h58);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_sck_pulses", 32'(rise_cnt - rbase), 32'd8);
        check("t1_mosi_bits", 32'(mosi_cap), 32'h58);
        tick(1);
        check("t1_valid_pulse", 32'(valid), 32'd0);
        check("t1_count", byte_count, exp_cnt(32'd1));

        // Divided clock, card returns 0xA5, divider changed mid-byte
        loopback = 1'b0;
        miso_pat = 8'hA5;
        start_xfer(8'hFF, 8'd3);
        tick(3);
        check("t2_sck_low_t4", 32'(sck), 32'd0);
        tick(1);
        check("t2_sck_rise_t5", 32'(sck), 32'd1);
        div = 8'd0;
        data_in = 8'h00;
        tick(59);
        check("t2_no_valid_t64", 32'(valid), 32'd0);
        tick(1);
        check("t2_valid_t65", 32'(valid), 32'd1);
        check("t2_data", 32'(data_out), 32'hA5);
        check("t2_mosi_bits", 32'(mosi_cap), 32'hFF);
        check("t2_info_miso", 32'(info_miso), 32'(miso_pat[miso_idx]));

        // Back-to-back with an ignored request while busy
        loopback = 1'b1;
        tick(1);
        vbase = valid_cnt;
        start_xfer(8'h40, 8'd0);
        tick(3);
        data_in = 8'hAA;
        req = 1'b1;
        tick(1);
        req = 1'b0;
        tick(12);
        check("t3_valid_a", 32'(valid), 32'd1);
        check("t3_data_a", 32'(data_out), 32'h40);
        tick(1);
        check("t3_idle_t18", 32'(busy), 32'd0);
        start_xfer(8'h00, 8'd0);
        check("t3_accept_t18", 32'(busy), 32'd1);
        tick(15);
        check("t3_no_valid_b", 32'(valid), 32'd0);
        tick(1);
        check("t3_valid_b", 32'(valid), 32'd1);
        check("t3_data_b", 32'(data_out), 32'h00);
        tick(40);
        check("t3_pulse_count", 32'(valid_cnt - vbase), 32'd2);

        // Synchronous clear while bit 4 is on the wire
        start_xfer(8'h3C, 8'd0);
        tick(6);
        check("t4_bit4_mosi", 32'(mosi), 32'd1);
        check("t4_busy_bit4", 32'(busy), 32'd1);
        vbase = valid_cnt;
        srst = 1'b1;
        req = 1'b1;
        tick(1);
        srst = 1'b0;
        req = 1'b0;
        check("t4_abort_busy", 32'(busy), 32'd0);
        check("t4_abort_sck", 32'(sck), 32'd0);
        check("t4_abort_cs", 32'(spi_cs), 32'd1);
        check("t4_abort_valid", 32'(valid), 32'd0);
        check("t4_abort_count", byte_count, 32'd0);
        tick(20);
        check("t4_no_pulse", 32'(valid_cnt - vbase), 32'd0);
        start_xfer(8'h81, 8'd0);
        wait_valid("t4_timeout");
        check("t4_after_data", 32'(data_out), 32'h81);
        tick(1);
        check("t4_after_count", byte_count, exp_cnt(32'd1));

        // Counter: async reset, three bytes, async reset
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("t5_rst_count", byte_count, 32'd0);
        for (int k = 0; k < 3; k++) begin
            start_xfer(8'(8'h11 * (k + 1)), 8'd1);
            wait_valid("t5_timeout");
            check("t5_data", 32'(data_out), 32'(8'h11 * (k + 1)));
            tick(1);
        end
        check("t5_count3", byte_count, exp_cnt(32'd3));
        rst = 1'b1;
        #2;
        check("t5_async_clear", byte_count, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        check("cs_hold", 32'(cs_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmc_spi_byte_layer.md
Name: mmc_spi_byte_layer

Overview:
Byte-level SPI master that sits directly below the MMC command-control layers (CMD0/CMD17/CMD24 sequencers) and consumes their byte requests. It accepts one 8-bit transfer per request, shifts it out MSB-first in SPI mode 0 while shifting in MISO, and returns the received byte with a one-cycle valid pulse. It also drives card chip-select and reports the live MISO level for busy polling.

Parameters:
P_DIV_W, 8, width of the runtime half-period divider input iDIV.

Ports:
iCLOCK  in  1  system clock.
iRESET  in  1  asynchronous active-high reset.
iRESET_SYNC  in  1  synchronous clear, same effect as iRESET.
iDIV  in  P_DIV_W  SCK half-period minus 1, in iCLOCK cycles.
iREQ  in  1  transfer request; accepted when oBUSY=0.
iCS  in  1  requested CS level (1 = deselected).
iDATA  in  8  byte to transmit.
oBUSY  out  1  transfer in progress.
oVALID  out  1  one-cycle pulse: byte complete.
oDATA  out  8  received byte, held until next completion.
oINFO_MISO  out  1  registered MISO level.
oBYTE_COUNT  out  32  completed-byte counter (optional feature).
oSPI_CLK  out  1  SCK.
oSPI_MOSI  out  1  MOSI.
oSPI_CS  out  1  card CS, active-low.
iSPI_MISO  in  1  MISO.

Behaviour:
- Reset (iRESET or iRESET_SYNC): oBUSY=0, oVALID=0, oDATA=0, oSPI_CLK=0, oSPI_MOSI=1, oSPI_CS=1, oINFO_MISO=1, oBYTE_COUNT=0. Mid-transfer reset aborts immediately; no oVALID.
- All outputs are registered. oINFO_MISO <= iSPI_MISO every cycle.
- States: IDLE, SHIFT_LOW (SCK=0), SHIFT_HIGH (SCK=1).
- IDLE: oSPI_CS <= iCS every cycle; oSPI_MOSI=1.
- Accept at cycle T: iREQ=1 and oBUSY=0. Latch iDATA, iCS and H=iDIV+1. At T+1: oBUSY=1, oSPI_MOSI=iDATA[7], oSPI_CLK=0, state SHIFT_LOW, bit index 7, half counter cleared.
- SHIFT_LOW: after H cycles, SCK rises. Sample iSPI_MISO into the shift register LSB on that edge, then enter SHIFT_HIGH.
- SHIFT_HIGH: after H cycles, SCK falls. If bit index 0: enter IDLE with oBUSY=0, oVALID=1 and oDATA=shifted byte, all in that cycle. Otherwise shift the next TX bit onto MOSI, decrement the index and enter SHIFT_LOW.
- Edge timing: rising edges at T+1+(2k+1)H and falling edges at T+1+(2k+2)H, for k=0..7. Completion at T+1+16H, so byte latency is 16H+1 cycles from accept.
- Back-to-back: the requester may assert iREQ in the cycle after oVALID, because oBUSY is already 0. This gives an accept-to-accept period of 16H+2 cycles.
- iREQ while oBUSY=1 is ignored with no queuing. Changes to iDIV, iCS or iDATA mid-transfer have no effect.
- oSPI_CS holds the latched value for the whole transfer.
- iRESET_SYNC has priority over a simultaneous iREQ.
- iDIV=0 gives H=1: SCK toggles every cycle and a byte takes 17 cycles.
- Every transfer, write or read, produces oVALID. Upper layers ignore it where it is not needed.

Optional Feature:
- Macro MMC_SPI_BYTE_COUNT_EN.
- When defined, oBYTE_COUNT increments by 1 in each cycle oVALID=1 and wraps from 0xFFFFFFFF to 0. It is cleared by iRESET or iRESET_SYNC.
- When undefined, oBYTE_COUNT is constant 0 and no counter logic is built.

Test Plan:
- Reset, then idle with iCS=1 -> oSPI_CS=1, oSPI_CLK=0, oSPI_MOSI=1, oBUSY=0, oVALID=0, oDATA=0x00.
- iDIV=0, iCS=0, request iDATA=0x58, MISO loopback to MOSI -> 8 SCK pulses; MOSI bits 0,1,0,1,1,0,0,0 on rising edges; oVALID at T+17; oDATA=0x58; oSPI_CS=0 throughout.
- iDIV=3, MISO model returns 0xA5 while request sends 0xFF -> first rising edge at T+5; oVALID at T+65; oDATA=0xA5. Change iDIV to 0 mid-byte -> timing unchanged.
- Back-to-back: 0x40 then 0x00 with iREQ reissued the cycle after oVALID, iDIV=0 -> second accept at T+18; a second iREQ asserted while busy -> ignored, exactly 2 oVALID pulses.
- Assert iRESET_SYNC at bit 4 of a transfer -> next cycle oBUSY=0, oSPI_CLK=0, oSPI_CS=1, no oVALID. A new request afterward completes normally.
- With MMC_SPI_BYTE_COUNT_EN, 3 transfers -> oBYTE_COUNT=3; then iRESET -> 0. Without the macro -> oBYTE_COUNT=0 always.
